dut_driver: RTL and testbench

Vector-execution stage on the target-side clock domain. Pops stimulus words from the stimulus FIFO read port, drives them onto the target design inputs, and holds each vector for a per-vector cycle count. It then samples the target outputs and pushes result words into the result FIFO write port, where the checker consumes them. It also executes design-interface commands (mask, idle value, target reset) popped from the design-interface FIFO.

---
 rtl/dut_driver.sv | 153 +++++++++++++++
 tb/tb_dut_driver.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_driver.sv
// Vector-execution stage: pops stimulus/design-interface words, drives the target,
// holds each vector for a programmed cycle count, and pushes masked target results.
module dut_driver #(
  parameter int STF_WIDTH   = 24,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int CMD_WIDTH   = 5,
  parameter int REQ_WIDTH   = 3,
  parameter int DIF_WIDTH   = REQ_WIDTH + CMD_WIDTH + STF_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic                             sfifo_rdempty,
  output logic                             sfifo_rdreq,
  input  logic [STF_WIDTH+CYCLE_RANGE:0]   sfifo_dataq,
  input  logic                             dififo_rdempty,
  output logic                             dififo_rdreq,
  input  logic [DIF_WIDTH-1:0]             dififo_dataq,
  input  logic                             rfifo_wrfull,
  output logic                             rfifo_wrreq,
  output logic [RTF_WIDTH+CYCLE_RANGE:0]   rfifo_data,
  output logic [STF_WIDTH-1:0]             dut_in,
  input  logic [RTF_WIDTH-1:0]             dut_out,
  output logic                             dut_reset,
  output logic                             busy
);

  localparam int CYC_W = CYCLE_RANGE + 1;
  localparam int CNT_W = (CYC_W > CMD_WIDTH) ? CYC_W : CMD_WIDTH;

  localparam logic [REQ_WIDTH-1:0] REQ_SET_MASK  = REQ_WIDTH'(1);
  localparam logic [REQ_WIDTH-1:0] REQ_SET_IDLE  = REQ_WIDTH'(2);
  localparam logic [REQ_WIDTH-1:0] REQ_RESET_DUT = REQ_WIDTH'(3);

  typedef enum logic [2:0] {IDLE, S_LOAD, WAIT, WRITE, D_LOAD, D_RST} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CYC_W-1:0]       r_cyc;
  logic [RTF_WIDTH-1:0]   r_res;
  logic [RTF_WIDTH-1:0]   r_mask;
  logic [STF_WIDTH-1:0]   r_idle;
  logic [STF_WIDTH-1:0]   r_dut_in;

  logic [REQ_WIDTH-1:0]   w_req;
  logic [CMD_WIDTH-1:0]   w_cmd;
  logic [STF_WIDTH-1:0]   w_data;
  logic                   w_take_d;
  logic                   w_take_s;
  logic                   w_restore;

  assign w_req     = dififo_dataq[DIF_WIDTH-1 -: REQ_WIDTH];
  assign w_cmd     = dififo_dataq[STF_WIDTH +: CMD_WIDTH];
  assign w_data    = dififo_dataq[STF_WIDTH-1:0];
  assign w_take_d  = enable && !dififo_rdempty;
  assign w_take_s  = enable && dififo_rdempty && !sfifo_rdempty;
  // Idle value goes back on the pins only when no further work is about to start.
  assign w_restore = (sfifo_rdempty && dififo_rdempty) || !enable;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_take_d)      w_next = D_LOAD;
        else if (w_take_s) w_next = S_LOAD;
      end
      S_LOAD:  w_next = WAIT;
      WAIT:    if (r_cnt == '0) w_next = WRITE;
      WRITE:   if (!rfifo_wrfull) w_next = IDLE;
      D_LOAD:  w_next = (w_req == REQ_RESET_DUT) ? D_RST : IDLE;
      D_RST:   if (r_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pops are gated by reset_n so every output reads 0 while reset is held.
  always_comb begin
    sfifo_rdreq  = 1'b0;
    dififo_rdreq = 1'b0;
    rfifo_wrreq  = 1'b0;
    dut_reset    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy         = 1'b0;
        dififo_rdreq = reset_n && w_take_d;
        sfifo_rdreq  = reset_n && w_take_s;
      end
      WRITE:   rfifo_wrreq = !rfifo_wrfull;
      D_RST:   dut_reset   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_cyc    <= '0;
      r_res    <= '0;
      r_mask   <= '1;
      r_idle   <= '0;
      r_dut_in <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_dut_in <= sfifo_dataq[STF_WIDTH-1:0];
          r_cyc    <= sfifo_dataq[STF_WIDTH +: CYC_W];
          r_cnt    <= CNT_W'(sfifo_dataq[STF_WIDTH +: CYC_W]);
        end
        WAIT: begin
          if (r_cnt == '0) r_res <= dut_out & r_mask;
          else             r_cnt <= r_cnt - CNT_W'(1);
        end
        WRITE: begin
          if (!rfifo_wrfull && w_restore) r_dut_in <= r_idle;
        end
        D_LOAD: begin
          case (w_req)
            REQ_SET_MASK: begin
              r_mask <= w_data[RTF_WIDTH-1:0];
              if (w_restore) r_dut_in <= r_idle;
            end
            REQ_SET_IDLE: begin
              r_idle   <= w_data;
              r_dut_in <= w_data;
            end
            REQ_RESET_DUT: r_cnt <= CNT_W'(w_cmd);
            default: if (w_restore) r_dut_in <= r_idle;
          endcase
        end
        D_RST: begin
          if (r_cnt == '0) begin
            if (w_restore) r_dut_in <= r_idle;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rfifo_data = {r_cyc, r_res};
  assign dut_in     = r_dut_in;

endmodule

// File: tb/tb_dut_driver.sv
// Self-checking bench for dut_driver: FIFO models around the DUT, table vectors,
// directed multi-cycle sequences and a randomized vector/mask run.
module tb_dut_driver;

  localparam int SW = 30;
  localparam int RW = 30;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          sfifo_rdempty = 1'b1;
  logic          sfifo_rdreq;
  logic [SW-1:0] sfifo_dataq = '0;
  logic          dififo_rdempty = 1'b1;
  logic          dififo_rdreq;
  logic [DW-1:0] dififo_dataq = '0;
  logic          rfifo_wrfull = 1'b0;
  logic          rfifo_wrreq;
  logic [RW-1:0] rfifo_data;
  logic [23:0]   dut_in;
  logic [23:0]   dut_out;
  logic          dut_reset;
  logic          busy;

  logic          loopback = 1'b1;
  logic [23:0]   ovr = '0;
  assign dut_out = loopback ? dut_in : ovr;

  always #5 clock = ~clock;

  dut_driver #(.STF_WIDTH(24), .RTF_WIDTH(24), .CYCLE_RANGE(5), .CMD_WIDTH(5), .REQ_WIDTH(3)) u_dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .sfifo_rdempty(sfifo_rdempty), .sfifo_rdreq(sfifo_rdreq), .sfifo_dataq(sfifo_dataq),
    .dififo_rdempty(dififo_rdempty), .dififo_rdreq(dififo_rdreq), .dififo_dataq(dififo_dataq),
    .rfifo_wrfull(rfifo_wrfull), .rfifo_wrreq(rfifo_wrreq), .rfifo_data(rfifo_data),
    .dut_in(dut_in), .dut_out(dut_out), .dut_reset(dut_reset), .busy(busy)
  );

  // Non-show-ahead FIFO models: q updates on the edge that sees rdreq.
  logic [SW-1:0] s_mem[$];
  logic [DW-1:0] d_mem[$];
  logic [RW-1:0] r_mem[$];
  int s_rd = 0;
  int d_rd = 0;
  int s_pops = 0;
  int d_pops = 0;
  int viol = 0;
  logic s_prev = 1'b0;
  logic d_prev = 1'b0;

  always @(posedge clock) begin
    if (sfifo_rdreq) begin
      if (s_rd < s_mem.size()) sfifo_dataq <= s_mem[s_rd];
      s_rd          <= s_rd + 1;
      sfifo_rdempty <= (s_rd + 1 >= s_mem.size());
    end else begin
      sfifo_rdempty <= (s_rd >= s_mem.size());
    end
  end

  always @(posedge clock) begin
    if (dififo_rdreq) begin
      if (d_rd < d_mem.size()) dififo_dataq <= d_mem[d_rd];
      d_rd           <= d_rd + 1;
      dififo_rdempty <= (d_rd + 1 >= d_mem.size());
    end else begin
      dififo_rdempty <= (d_rd >= d_mem.size());
    end
  end

  always @(posedge clock) begin
    if (rfifo_wrreq) r_mem.push_back(rfifo_data);
  end

  always @(posedge clock) begin
    s_pops <= s_pops + int'(sfifo_rdreq);
    d_pops <= d_pops + int'(dififo_rdreq);
    viol   <= viol + int'(sfifo_rdreq && (sfifo_rdempty || s_prev))
                   + int'(dififo_rdreq && (dififo_rdempty || d_prev))
                   + int'(rfifo_wrreq && rfifo_wrfull)
                   + int'(sfifo_rdreq && dififo_rdreq);
    s_prev <= sfifo_rdreq;
    d_prev <= dififo_rdreq;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input int idx, input logic [RW-1:0] exp);
    n_chk++;
    if (idx >= r_mem.size()) begin
      n_fail++;
      $display("FAIL %s: result %0d missing, expected %0h", name, idx, exp);
    end else if (r_mem[idx] !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, r_mem[idx], exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting, expected DUT activity", name);
  endtask

  task automatic push_s(input int cyc, input logic [23:0] v);
    s_mem.push_back({6'(cyc), v});
  endtask

  task automatic push_d(input int req, input int cmd, input logic [23:0] d);
    d_mem.push_back({3'(req), 5'(cmd), d});
  endtask

  task automatic wait_rdreq_s(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (sfifo_rdreq) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy && s_rd == s_mem.size() && d_rd == d_mem.size()) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_res(input string name, input int n, input int budget, input bit rnd_full);
    for (int i = 0; i < budget && r_mem.size() < n; i++) begin
      @(negedge clock);
      if (rnd_full) rfifo_wrfull = ($urandom_range(0, 2) == 0);
    end
    rfifo_wrfull = 1'b0;
    if (r_mem.size() < n) timeout_fail(name);
  endtask

  task automatic set_mask(input logic [23:0] m);
    push_d(1, 0, m);
    wait_idle("set_mask", 40);
  endtask

  typedef struct {
    int          cyc;
    logic [23:0] vec;
    logic [23:0] mask;
    logic [RW-1:0] exp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    bit ok;
    int base;
    int bad;
    int rc;
    int first;
    int p0;
    logic [RW-1:0] held;
    logic [RW-1:0] expq[$];
    logic [23:0] m;
    logic [23:0] v;
    int cyc;

    tbl[0] = '{0,  24'hA5A5A5, 24'hFFFFFF, {6'd0,  24'hA5A5A5}};
    tbl[1] = '{3,  24'h123456, 24'h0000FF, {6'd3,  24'h000056}};
    tbl[2] = '{63, 24'hFFFFFF, 24'hF0F0F0, {6'd63, 24'hF0F0F0}};
    tbl[3] = '{1,  24'h000000, 24'hFFFFFF, {6'd1,  24'h000000}};
    tbl[4] = '{5,  24'hC3C3C3, 24'h000000, {6'd5,  24'h000000}};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_sfifo_rdreq", sfifo_rdreq, 0);
    chk("rst_dififo_rdreq", dififo_rdreq, 0);
    chk("rst_wrreq", rfifo_wrreq, 0);
    chk("rst_rfifo_data", rfifo_data, 0);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_dut_reset", dut_reset, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clock);

    // First vector latency, cycles=0
    base = r_mem.size();
    push_s(0, 24'hA5A5A5);
    wait_rdreq_s(ok);
    if (!ok) timeout_fail("t1_rdreq");
    else begin
      @(negedge clock);
      chk("t1_pre_apply_dut_in", dut_in, 0);
      chk("t1_busy", busy, 1);
      @(negedge clock);
      chk("t1_apply_dut_in", dut_in, 24'hA5A5A5);
      chk("t1_no_early_wrreq", rfifo_wrreq, 0);
      @(negedge clock);
      chk("t1_wrreq", rfifo_wrreq, 1);
      chk("t1_rfifo_data", rfifo_data, {6'd0, 24'hA5A5A5});
      @(negedge clock);
      chk("t1_wrreq_single", rfifo_wrreq, 0);
      chk("t1_idle", busy, 0);
      chk("t1_idle_restore", dut_in, 0);
      chk("t1_push_count", r_mem.size(), base + 1);
      chk_res("t1_result", base, {6'd0, 24'hA5A5A5});
    end

    // Table vectors: mask then vector
    foreach (tbl[i]) begin
      set_mask(tbl[i].mask);
      base = r_mem.size();
      push_s(tbl[i].cyc, tbl[i].vec);
      wait_res("tbl_wait", base + 1, 200, 1'b0);
      chk_res("tbl_result", base, tbl[i].exp);
    end
    set_mask(24'hFFFFFF);

    // Max hold count with output change mid-hold
    base = r_mem.size();
    loopback = 1'b0;
    ovr = 24'h000001;
    push_s(63, 24'h000001);
    wait_rdreq_s(ok);
    if (!ok) timeout_fail("t2_rdreq");
    else begin
      repeat (2) @(negedge clock);
      chk("t2_apply", dut_in, 24'h000001);
      repeat (40) @(negedge clock);
      ovr = 24'h123456;
      repeat (23) @(negedge clock);
      chk("t2_no_early_write", rfifo_wrreq, 0);
      @(negedge clock);
      chk("t2_write_at_64", rfifo_wrreq, 1);
      chk("t2_rfifo_data", rfifo_data, {6'd63, 24'h123456});
      wait_idle("t2_idle", 20);
      chk_res("t2_result", base, {6'd63, 24'h123456});
    end

    // Mask applied to result
    base = r_mem.size();
    ovr = 24'hABCDEF;
    push_d(1, 0, 24'h0000FF);
    push_s(2, 24'h111111);
    wait_res("t3_wait", base + 1, 100, 1'b0);
    chk_res("t3_masked", base, {6'd2, 24'h0000EF});
    wait_idle("t3_idle", 40);
    set_mask(24'hFFFFFF);
    loopback = 1'b1;

    // Result FIFO full stall
    base = r_mem.size();
    rfifo_wrfull = 1'b1;
    push_s(1, 24'h5A5A5A);
    push_s(0, 24'h654321);
    wait_rdreq_s(ok);
    if (!ok) timeout_fail("t4_rdreq");
    else begin
      repeat (4) @(negedge clock);
      held = rfifo_data;
      p0 = s_pops;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        if (rfifo_wrreq !== 1'b0 || rfifo_data !== held || dut_in !== 24'h5A5A5A) bad++;
      end
      chk("t4_stall_bad_cycles", bad, 0);
      chk("t4_held_data", held, {6'd1, 24'h5A5A5A});
      chk("t4_no_pop_while_full", s_pops - p0, 0);
      chk("t4_no_push_while_full", r_mem.size(), base);
      rfifo_wrfull = 1'b0;
      #1;
      chk("t4_wrreq_after_full", rfifo_wrreq, 1);
      @(negedge clock);
      chk("t4_single_push", r_mem.size(), base + 1);
      chk("t4_wrreq_drop", rfifo_wrreq, 0);
      wait_res("t4_wait", base + 2, 100, 1'b0);
      chk_res("t4_first", base, {6'd1, 24'h5A5A5A});
      chk_res("t4_second", base + 1, {6'd0, 24'h654321});
    end
    wait_idle("t4_idle", 40);

    // Priority and target reset pulse
    base = r_mem.size();
    push_s(0, 24'h0F0F0F);
    push_d(3, 4, 24'h000000);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (sfifo_rdreq || dififo_rdreq) ok = 1'b1;
    end
    if (!ok) timeout_fail("t5_rdreq");
    else begin
      chk("t5_dififo_first", dififo_rdreq, 1);
      chk("t5_sfifo_wait", sfifo_rdreq, 0);
      rc = 0;
      first = -1;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clock);
        if (dut_reset) begin
          rc++;
          if (first < 0) first = i;
        end
      end
      chk("t5_reset_width", rc, 5);
      chk("t5_reset_start", first, 2);
      wait_res("t5_wait", base + 1, 100, 1'b0);
      chk_res("t5_vector_after_reset", base, {6'd0, 24'h0F0F0F});
    end
    wait_idle("t5_idle", 40);

    push_d(3, 0, 24'h000000);
    rc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (dut_reset) rc++;
    end
    chk("t5_reset_width_cmd0", rc, 1);

    // Idle value and unknown request
    push_d(2, 0, 24'h3C3C3C);
    wait_idle("t6_idle", 40);
    chk("t6_set_idle", dut_in, 24'h3C3C3C);
    push_d(7, 31, 24'h000000);
    wait_idle("t6_unk", 40);
    chk("t6_unknown_noeffect", dut_in, 24'h3C3C3C);
    base = r_mem.size();
    push_s(0, 24'h5555AA);
    wait_res("t6_wait", base + 1, 100, 1'b0);
    chk_res("t6_mask_intact", base, {6'd0, 24'h5555AA});
    wait_idle("t6_idle2", 40);
    chk("t6_restore_idle", dut_in, 24'h3C3C3C);
    push_d(2, 0, 24'h000000);
    wait_idle("t6_idle3", 40);

    // Reset mid-WAIT
    base = r_mem.size();
    push_s(20, 24'h777777);
    wait_rdreq_s(ok);
    if (!ok) timeout_fail("t7_rdreq");
    else begin
      repeat (7) @(negedge clock);
      chk("t7_in_wait", dut_in, 24'h777777);
      reset_n = 1'b0;
      #1;
      chk("t7_rst_dut_in", dut_in, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_wrreq", rfifo_wrreq, 0);
      chk("t7_rst_data", rfifo_data, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (30) @(negedge clock);
      chk("t7_no_push", r_mem.size(), base);
    end

    // enable=0 holds off pops
    enable = 1'b0;
    base = r_mem.size();
    p0 = s_pops + d_pops;
    push_d(1, 0, 24'hFFFFFF);
    push_s(0, 24'h246810);
    repeat (12) @(negedge clock);
    chk("t8_no_pops_disabled", s_pops + d_pops - p0, 0);
    chk("t8_idle_disabled", busy, 0);
    enable = 1'b1;
    wait_res("t8_wait", base + 1, 100, 1'b0);
    chk_res("t8_result", base, {6'd0, 24'h246810});
    wait_idle("t8_idle", 40);

    // Randomized vectors and masks with random backpressure
    for (int b = 0; b < 5; b++) begin
      m = (b == 0) ? 24'hFFFFFF : 24'($urandom);
      if (b != 0) set_mask(m);
      base = r_mem.size();
      expq.delete();
      for (int j = 0; j < 8; j++) begin
        cyc = $urandom_range(0, 7);
        v = 24'($urandom);
        push_s(cyc, v);
        expq.push_back({6'(cyc), v & m});
      end
      wait_res("rnd_wait", base + 8, 600, 1'b1);
      foreach (expq[j]) chk_res("rnd_result", base + j, expq[j]);
      wait_idle("rnd_idle", 40);
    end

    chk("protocol_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
